maxpool2x2_stream: RTL and testbench
====================================

Name: maxpool2x2_stream

Overview:
- Downstream stage of the convolution engine.
- Consumes the row-major 16-bit result stream that the engine emits one element per clock, and applies 2x2 stride-2 pooling (max by default).
- Emits the pooled matrix as a row-major stream with a valid strobe and an end-of-frame pulse.
- Dimensions use the codebase encoding: the port carries count minus one.

Parameters:
- DATA_W, 16, element width; matches the conv output width.
- DIM_W, 4, width of the dimension ports and counters; maximum matrix side is 2**DIM_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  in_data carries one element this cycle; no backpressure.
- in_data  input  DATA_W  unsigned element, row-major order.
- in_rows  input  DIM_W  input height minus one; sampled on the first beat of a frame.
- in_cols  input  DIM_W  input width minus one; sampled on the first beat of a frame.
- out_valid  output  1  out_data is valid this cycle (single-cycle strobe).
- out_data  output  DATA_W  pooled element, row-major order.
- frame_done  output  1  one-cycle pulse after the last input beat of a frame.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, frame_done=0.
  - Row/column counters cleared; FSM set to S_IDLE.
  - Line buffer contents are don't-care.
- Dimensions: H = in_rows+1, W = in_cols+1.
  - Output size is floor(H/2) x floor(W/2).
  - An odd last row or odd last column is consumed and discarded.
- FSM:
  - S_IDLE: on in_valid, latch H and W, process the beat as (r=0,c=0), go to S_RUN.
  - S_RUN: each in_valid beat advances c; at c==W-1, c wraps to 0 and r increments.
  - On the beat at r==H-1, c==W-1, go to S_IDLE.
  - in_valid=0 cycles stall the counters; gaps of any length are legal.
- Per accepted beat, with x=in_data:
  - c even: hold register h <= x.
  - r even, c odd (c<=W-1, pair complete): line_buf[c>>1] <= max(h,x).
  - r odd, c odd, and r<=2*floor(H/2)-1: out_data <= max(line_buf[c>>1],h,x); out_valid=1 on the next cycle.
  - Beats in a trailing odd row or odd column produce no line_buf write and no output.
- Latency: exactly 1 cycle from the completing input beat to out_valid.
- frame_done is registered and rises in the same cycle as the final out_valid, if there is one; otherwise 1 cycle after the last beat.
- Degenerate frames (H==1 or W==1): all beats consumed, no out_valid, frame_done still pulses.
- Back-to-back frames: a beat arriving in the cycle after the last beat starts a new frame with freshly sampled dimensions.
- Dimension changes mid-frame are ignored.
- Arithmetic is unsigned compare; the result width is DATA_W with no truncation.
- Reset mid-frame aborts the frame: no frame_done, no partial output. The next beat after release is (0,0).

Optional Feature:
- Macro POOL_AVG_EN.
- Defined: replace max with average.
  - Row pair stores a DATA_W+1 sum; the final sum is DATA_W+2 bits.
  - out_data = sum>>2 (floor); latency and timing are unchanged.
- Undefined: max pooling as above; no adder logic present.

Decomposition:
- Shared package conv_pkg holds:
  - DATA_W and DIM_W defaults.
  - MAX_DIM = 2**DIM_W.
  - Pool FSM state typedef {S_IDLE, S_RUN}.
  - An element typedef of DATA_W bits.
- One sub-module, pool_line_buf: MAX_DIM/2-entry DATA_W (DATA_W+1 under POOL_AVG_EN) register array with synchronous write and combinational read.

Test Plan:
- Max 4x4: in_rows=3, in_cols=3, values 1..16 back-to-back.
  - Response: out_data 6,8,14,16, each 1 cycle after inputs 6,8,14,16.
  - frame_done coincides with 16.
- Odd size 3x5: in_rows=2, in_cols=4, values 1..15.
  - Response: outputs 7,9 only; row 3 and column 5 dropped.
  - frame_done 1 cycle after beat 15.
- Degenerate 1x8: in_rows=0, in_cols=7.
  - Response: no out_valid; frame_done pulses once, 1 cycle after beat 8.
- Gapped/back-to-back: 4x4 frame with in_valid=0 inserted every other cycle, then a 2x2 frame {100,3,7,50} immediately after.
  - Response: first frame outputs 6,8,14,16; second frame outputs 100; two frame_done pulses.
- Reset mid-frame: assert rst_n=0 after 9 beats of a 4x4 frame, then release and send a full 4x4 frame.
  - Response: outputs cleared immediately; afterwards only 6,8,14,16 appear.
- With POOL_AVG_EN defined, 4x4 frame 1..16.
  - Response: out_data 3,5,11,13; 4x4 frame of all 0xFFFF yields 0xFFFF with no overflow.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution engine back end: default widths,
// the pooling FSM state type and the element type.
package conv_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_DIM_W  = 4;
    localparam int unsigned MAX_DIM    = 2 ** DEF_DIM_W;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } pool_state_e;

    typedef logic [DEF_DATA_W-1:0] elem_t;

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer for the 2x2 pooler: one partial result per column pair of the
// even input row. Synchronous write, combinational read, no reset (contents
// are always written before they are read within a frame).
module pool_line_buf #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store the completed even-row pair result.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 pooling over a row-major element stream.
// Max pooling by default; define POOL_AVG_EN to switch to average pooling.
// Dimension inputs carry count minus one and are sampled on a frame's first beat.
module maxpool2x2_stream
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DIM_W  = DEF_DIM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [DIM_W-1:0]  in_rows_i,
    input  logic [DIM_W-1:0]  in_cols_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              frame_done_o
);

    localparam int unsigned IdxW  = DIM_W - 1;
    localparam int unsigned Depth = 2 ** IdxW;
`ifdef POOL_AVG_EN
    localparam int unsigned LbW = DATA_W + 1;
`else
    localparam int unsigned LbW = DATA_W;
`endif

    pool_state_e       state_q, state_d;
    logic [DIM_W-1:0]  rows_q, rows_d;
    logic [DIM_W-1:0]  cols_q, cols_d;
    logic [DIM_W-1:0]  r_q, r_d;
    logic [DIM_W-1:0]  c_q, c_d;
    logic [DATA_W-1:0] h_q, h_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              frame_done_q, frame_done_d;

    // Position and dimensions of the current beat; a beat in S_IDLE is (0,0)
    // of a new frame and uses the live dimension inputs.
    logic [DIM_W-1:0]  cur_r, cur_c, cur_rows, cur_cols;
    logic              last_r, last_c;
    logic              lb_we, emit;
    logic [IdxW-1:0]   lb_idx;
    logic [LbW-1:0]    lb_wdata, lb_rdata;
    logic [DATA_W-1:0] pooled;

    // Select beat coordinates and frame dimensions.
    always_comb begin
        cur_r    = r_q;
        cur_c    = c_q;
        cur_rows = rows_q;
        cur_cols = cols_q;
        if (state_q == S_IDLE) begin
            cur_r    = '0;
            cur_c    = '0;
            cur_rows = in_rows_i;
            cur_cols = in_cols_i;
        end
    end

    assign last_r = (cur_r == cur_rows);
    assign last_c = (cur_c == cur_cols);
    assign lb_idx = cur_c[DIM_W-1:1];

    // An odd c always closes a pair. An even row that is also the last row is
    // the trailing row of an odd-height frame and is discarded.
    assign lb_we = in_valid_i & cur_c[0] & ~cur_r[0] & ~last_r;
    assign emit  = in_valid_i & cur_c[0] & cur_r[0];

`ifdef POOL_AVG_EN
    logic [DATA_W+1:0] quad_sum;

    // Sum the pair into the line buffer and the full window at the output.
    always_comb begin
        lb_wdata = {1'b0, h_q} + {1'b0, in_data_i};
        quad_sum = {1'b0, lb_rdata} + {2'b00, h_q} + {2'b00, in_data_i};
        pooled   = quad_sum[DATA_W+1:2];
    end
`else
    logic [DATA_W-1:0] pair_max;

    // Unsigned max of the pair, then of the window.
    always_comb begin
        pair_max = (h_q > in_data_i) ? h_q : in_data_i;
        lb_wdata = pair_max;
        pooled   = (lb_rdata > pair_max) ? lb_rdata : pair_max;
    end
`endif

    pool_line_buf #(
        .DEPTH (Depth),
        .WIDTH (LbW),
        .IDX_W (IdxW)
    ) u_line_buf (
        .clk     (clk),
        .we_i    (lb_we),
        .waddr_i (lb_idx),
        .wdata_i (lb_wdata),
        .raddr_i (lb_idx),
        .rdata_o (lb_rdata)
    );

    // Next-state: frame FSM, counters, hold register and output strobes.
    always_comb begin
        state_d      = state_q;
        rows_d       = rows_q;
        cols_d       = cols_q;
        r_d          = r_q;
        c_d          = c_q;
        h_d          = h_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        frame_done_d = 1'b0;

        if (in_valid_i) begin
            rows_d = cur_rows;
            cols_d = cur_cols;
            if (!cur_c[0]) begin
                h_d = in_data_i;
            end
            if (emit) begin
                out_valid_d = 1'b1;
                out_data_d  = pooled;
            end
            if (last_r && last_c) begin
                state_d      = S_IDLE;
                r_d          = '0;
                c_d          = '0;
                frame_done_d = 1'b1;
            end else begin
                state_d = S_RUN;
                if (last_c) begin
                    c_d = '0;
                    r_d = cur_r + 1'b1;
                end else begin
                    c_d = cur_c + 1'b1;
                    r_d = cur_r;
                end
            end
        end
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rows_q       <= '0;
            cols_q       <= '0;
            r_q          <= '0;
            c_q          <= '0;
            h_q          <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            r_q          <= r_d;
            c_q          <= c_d;
            h_q          <= h_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed table-driven bench for maxpool2x2_stream (max or, with POOL_AVG_EN,
// average pooling). Each record is one clock: inputs for that cycle and the
// outputs expected right after the edge that consumes them.
module tb_maxpool2x2_stream;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic [3:0]  rows;
        logic [3:0]  cols;
        logic        ev;
        logic [15:0] ed;
        logic        edone;
    } vec_t;

`ifdef POOL_AVG_EN
    localparam logic [15:0] E4_6 = 16'd3, E4_8 = 16'd5, E4_14 = 16'd11, E4_16 = 16'd13;
    localparam logic [15:0] E35_7 = 16'd4, E35_9 = 16'd6;
    localparam logic [15:0] E22 = 16'd40;
    localparam logic [15:0] E22U = 16'h4000;
`else
    localparam logic [15:0] E4_6 = 16'd6, E4_8 = 16'd8, E4_14 = 16'd14, E4_16 = 16'd16;
    localparam logic [15:0] E35_7 = 16'd7, E35_9 = 16'd9;
    localparam logic [15:0] E22 = 16'd100;
    localparam logic [15:0] E22U = 16'h8000;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_rows;
    logic [3:0]  in_cols;
    logic        out_valid;
    logic [15:0] out_data;
    logic        frame_done;

    int total;
    int bad;
    vec_t tbl[$];

    maxpool2x2_stream dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_rows_i    (in_rows),
        .in_cols_i    (in_cols),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .frame_done_o (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic add(input logic v, input logic [15:0] d, input logic [3:0] rows,
                       input logic [3:0] cols, input logic ev, input logic [15:0] ed,
                       input logic edone);
        vec_t t;
        t.v = v; t.d = d; t.rows = rows; t.cols = cols;
        t.ev = ev; t.ed = ed; t.edone = edone;
        tbl.push_back(t);
    endtask

    task automatic apply(input vec_t t, input string tag);
        @(negedge clk);
        in_valid = t.v;
        in_data  = t.d;
        in_rows  = t.rows;
        in_cols  = t.cols;
        @(posedge clk);
        #1;
        check({tag, " out_valid"}, {15'd0, out_valid}, {15'd0, t.ev});
        check({tag, " frame_done"}, {15'd0, frame_done}, {15'd0, t.edone});
        if (t.ev) check({tag, " out_data"}, out_data, t.ed);
    endtask

    function automatic logic [15:0] exp4(input int v);
        case (v)
            6:       return E4_6;
            8:       return E4_8;
            14:      return E4_14;
            16:      return E4_16;
            default: return 16'd0;
        endcase
    endfunction

    task automatic add_4x4_frame();
        for (int v = 1; v <= 16; v++) begin
            add(1'b1, 16'(v), 4'd3, 4'd3, (v == 6 || v == 8 || v == 14 || v == 16),
                exp4(v), (v == 16));
        end
    endtask

    initial begin
        vec_t t;
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_rows  = '0;
        in_cols  = '0;
        #1;
        check("reset out_valid", {15'd0, out_valid}, 16'd0);
        check("reset out_data", out_data, 16'd0);
        check("reset frame_done", {15'd0, frame_done}, 16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 4x4, values 1..16
        add_4x4_frame();
        add(1'b0, 16'hDEAD, 4'd3, 4'd3, 1'b0, 16'd0, 1'b0);
        // 3x5, dimension inputs scrambled after the first beat
        for (int v = 1; v <= 15; v++) begin
            add(1'b1, 16'(v), (v == 1) ? 4'd2 : 4'd7, (v == 1) ? 4'd4 : 4'd1,
                (v == 7 || v == 9), (v == 7) ? E35_7 : E35_9, (v == 15));
        end
        add(1'b0, 16'hDEAD, 4'd0, 4'd0, 1'b0, 16'd0, 1'b0);
        // 1x8 degenerate
        for (int v = 1; v <= 8; v++) begin
            add(1'b1, 16'(v * 100), 4'd0, 4'd7, 1'b0, 16'd0, (v == 8));
        end
        // 3x1 degenerate
        for (int v = 1; v <= 3; v++) begin
            add(1'b1, 16'hF000, 4'd2, 4'd0, 1'b0, 16'd0, (v == 3));
        end
        add(1'b0, 16'hDEAD, 4'd0, 4'd0, 1'b0, 16'd0, 1'b0);
        // gapped 4x4, then 2x2 back-to-back
        for (int v = 1; v <= 16; v++) begin
            add(1'b1, 16'(v), 4'd3, 4'd3, (v == 6 || v == 8 || v == 14 || v == 16),
                exp4(v), (v == 16));
            if (v != 16) add(1'b0, 16'hBEEF, 4'd9, 4'd9, 1'b0, 16'd0, 1'b0);
        end
        add(1'b1, 16'd100, 4'd1, 4'd1, 1'b0, 16'd0, 1'b0);
        add(1'b1, 16'd3,   4'd1, 4'd1, 1'b0, 16'd0, 1'b0);
        add(1'b1, 16'd7,   4'd1, 4'd1, 1'b0, 16'd0, 1'b0);
        add(1'b1, 16'd50,  4'd1, 4'd1, 1'b1, E22,   1'b1);
        add(1'b0, 16'hDEAD, 4'd0, 4'd0, 1'b0, 16'd0, 1'b0);
        // 2x2 unsigned compare / carry
        add(1'b1, 16'h7FFF, 4'd1, 4'd1, 1'b0, 16'd0, 1'b0);
        add(1'b1, 16'h8000, 4'd1, 4'd1, 1'b0, 16'd0, 1'b0);
        add(1'b1, 16'd1,    4'd1, 4'd1, 1'b0, 16'd0, 1'b0);
        add(1'b1, 16'd2,    4'd1, 4'd1, 1'b1, E22U,  1'b1);
        // 4x4 all-ones saturating values
        for (int v = 1; v <= 16; v++) begin
            add(1'b1, 16'hFFFF, 4'd3, 4'd3, (v == 6 || v == 8 || v == 14 || v == 16),
                16'hFFFF, (v == 16));
        end
        add(1'b0, 16'hDEAD, 4'd0, 4'd0, 1'b0, 16'd0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a 4x4 frame after 9 beats.
        tbl.delete();
        add_4x4_frame();
        for (int i = 0; i < 9; i++) apply(tbl[i], $sformatf("pre_rst%0d", i));
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst out_valid", {15'd0, out_valid}, 16'd0);
        check("midrst out_data", out_data, 16'd0);
        check("midrst frame_done", {15'd0, frame_done}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        t.v = 1'b0; t.d = 16'h0; t.rows = 4'd3; t.cols = 4'd3;
        t.ev = 1'b0; t.ed = 16'd0; t.edone = 1'b0;
        apply(t, "post_rst_idle");
        for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("post_rst%0d", i));
        apply(t, "post_rst_tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
